pfe_dispatch: RTL and testbench
===============================

PFE_DISPATCH -- requirements
Module: pfe_dispatch

Interface
REQ-001 SHALL have parameter ADDR_W, default 39, line-address width.
REQ-002 SHALL have parameter CNT_W, default 4, prefetch-count width.
REQ-003 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports op_valid in 1, op_retry out 1: prefetch-op handshake; transfer when op_valid && !op_retry.
REQ-006 SHALL have ports op_addr in ADDR_W (start line), op_stride in 12 (signed line stride), op_count in CNT_W (number of lines).
REQ-007 SHALL have ports reqN_valid out 1, reqN_retry in 1, reqN_addr out ADDR_W, for N=0,1: per-pipe dcache prefetch requests.
REQ-008 SHALL have port busy  out  1  high while an op is being expanded.
REQ-009 SHALL have port issued_total  out  16  count of completed request transfers, both pipes.

Function
REQ-010 SHALL implement FSM states IDLE and ISSUE.
REQ-011 In IDLE, op_retry SHALL be 0; on an op transfer with op_count!=0: load cur_addr=op_addr and remaining=op_count, then go to ISSUE.
REQ-012 On an op transfer with op_count==0, the op SHALL be dropped and the FSM SHALL stay in IDLE.
REQ-013 In ISSUE, op_retry SHALL be 1 and busy SHALL be 1; in IDLE, busy SHALL be 0.
REQ-014 Target pipe SHALL be cur_addr[0]: line-interleaved, 0 -> req0, 1 -> req1.
REQ-015 Each pipe SHALL have one output slot; a slot is free when its valid is 0 or it transfers this cycle (valid && !retry).
REQ-016 In ISSUE, if the target slot is free: load cur_addr into it, set its valid, set cur_addr += sign-extended stride modulo 2^ADDR_W, and decrement remaining.
REQ-017 In ISSUE, if the target slot is not free, the FSM SHALL stall with no state change.
REQ-018 At most one slot load SHALL occur per cycle.
REQ-019 A loaded request SHALL appear on reqN_valid/reqN_addr the cycle after the load, i.e. two cycles after op acceptance at minimum.
REQ-020 reqN_valid and reqN_addr SHALL hold stable while reqN_retry=1.
REQ-021 A slot whose request transfers without a simultaneous reload SHALL clear its valid the next cycle.
REQ-022 Both pipe slots MAY be valid simultaneously, and they drain independently.
REQ-023 When the load that makes remaining 0 occurs, the FSM SHALL return to IDLE the same edge; a new op SHALL be accepted the following cycle while slots still drain.
REQ-024 issued_total SHALL increment by the number of reqN transfers each cycle (0, 1 or 2) and saturate at 16'hFFFF.
REQ-025 Request order per pipe SHALL equal generation order; no request SHALL be lost or duplicated under retry.

Reset
REQ-026 reset low SHALL immediately force: FSM=IDLE, op_retry=0, busy=0, req0_valid=0, req1_valid=0, reqN_addr=0, issued_total=0, cur_addr=0, remaining=0.
REQ-027 Reset asserted mid-op SHALL abandon all pending and slotted requests; after release the block SHALL be in IDLE, ready to accept.

Configuration
REQ-028 Macro PFE_DEDUP_EN defined: an op with op_stride==0 SHALL load remaining=1, issuing exactly one request.
REQ-029 Macro PFE_DEDUP_EN undefined: a stride-0 op SHALL issue op_count identical requests.

Verification
REQ-030 Op addr=0x100, stride=1, count=4, no retry -> req0 0x100, req1 0x101, req0 0x102, req1 0x103; issued_total=4; busy low after the 4th load.
REQ-031 Op addr=0x10, stride=2, count=3, with req0_retry high for 5 cycles -> req0 holds 0x10 stable for 5 cycles, then 0x12, then 0x14; FSM stalls; nothing appears on req1.
REQ-032 Op addr=0x0, stride=-1, count=2 -> requests 0x0 and 2^39-1 (wrap); the second request goes on req1.
REQ-033 Op stride=0, count=5 -> one request with PFE_DEDUP_EN defined; five identical requests without it.
REQ-034 Assert reset low mid-op with both slots valid -> all outputs 0 immediately; after release, op count=0 -> dropped, busy stays 0.
REQ-035 Preload issued_total to 0xFFFE, then complete 3 transfers -> issued_total=0xFFFF.

Source files
------------

// File: rtl/pfe_dispatch_if.sv
// rtl/pfe_dispatch_if.sv - prefetch-op and per-pipe request handshake bundle
interface pfe_dispatch_if #(
    parameter int ADDR_W = 39,
    parameter int CNT_W  = 4
);
    logic              op_valid;
    logic              op_retry;
    logic [ADDR_W-1:0] op_addr;
    logic [11:0]       op_stride;
    logic [CNT_W-1:0]  op_count;
    logic              req0_valid;
    logic              req0_retry;
    logic [ADDR_W-1:0] req0_addr;
    logic              req1_valid;
    logic              req1_retry;
    logic [ADDR_W-1:0] req1_addr;

    modport master (
        output op_valid, op_addr, op_stride, op_count, req0_retry, req1_retry,
        input  op_retry, req0_valid, req0_addr, req1_valid, req1_addr
    );

    modport slave (
        input  op_valid, op_addr, op_stride, op_count, req0_retry, req1_retry,
        output op_retry, req0_valid, req0_addr, req1_valid, req1_addr
    );
endinterface

// File: rtl/pfe_dispatch.sv
// rtl/pfe_dispatch.sv - expands strided prefetch ops into line-interleaved dcache requests
// Optional PFE_DEDUP_EN: a stride-0 op issues a single request instead of op_count copies.
module pfe_dispatch #(
    parameter int ADDR_W = 39,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    pfe_dispatch_if.slave     bus,
    output logic              busy,
    output logic [15:0]       issued_total
);
    typedef enum logic {IDLE, ISSUE} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cur_q;
    logic [CNT_W-1:0]  rem_q;
    logic [11:0]       stride_q;
    logic              v0_q, v1_q;
    logic [ADDR_W-1:0] a0_q, a1_q;
    logic [15:0]       total_q;

    logic              xfer0, xfer1, free0, free1, load;
    logic [CNT_W-1:0]  count_d;
    logic [ADDR_W-1:0] cur_d;
    logic [16:0]       sum_d;
    logic [15:0]       total_d;

    always_comb begin
        xfer0 = v0_q && !bus.req0_retry;
        xfer1 = v1_q && !bus.req1_retry;
        free0 = !v0_q || xfer0;
        free1 = !v1_q || xfer1;
        load  = (state_q == ISSUE) && (cur_q[0] ? free1 : free0);
        cur_d = cur_q + {{(ADDR_W-12){stride_q[11]}}, stride_q};
`ifdef PFE_DEDUP_EN
        count_d = (bus.op_stride == 12'd0 && bus.op_count != '0) ? CNT_W'(1) : bus.op_count;
`else
        count_d = bus.op_count;
`endif
        sum_d   = {1'b0, total_q} + {16'b0, xfer0} + {16'b0, xfer1};
        total_d = sum_d[16] ? 16'hFFFF : sum_d[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            rem_q    <= '0;
            stride_q <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            a0_q     <= '0;
            a1_q     <= '0;
            total_q  <= '0;
        end else begin
            // A transfer frees the slot; a reload below in the same cycle overrides the clear.
            if (xfer0) v0_q <= 1'b0;
            if (xfer1) v1_q <= 1'b0;
            total_q <= total_d;
            case (state_q)
                IDLE: begin
                    if (bus.op_valid && count_d != '0) begin
                        cur_q    <= bus.op_addr;
                        rem_q    <= count_d;
                        stride_q <= bus.op_stride;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (load) begin
                        if (cur_q[0]) begin
                            v1_q <= 1'b1;
                            a1_q <= cur_q;
                        end else begin
                            v0_q <= 1'b1;
                            a0_q <= cur_q;
                        end
                        cur_q <= cur_d;
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.op_retry   = (state_q == ISSUE);
    assign busy           = (state_q == ISSUE);
    assign bus.req0_valid = v0_q;
    assign bus.req0_addr  = a0_q;
    assign bus.req1_valid = v1_q;
    assign bus.req1_addr  = a1_q;
    assign issued_total   = total_q;
endmodule

// File: tb/tb_pfe_dispatch.sv
// tb/tb_pfe_dispatch.sv - directed bench with per-pipe request queue model for pfe_dispatch
module tb_pfe_dispatch;
    localparam int AW = 39;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] issued_total;

    pfe_dispatch_if #(.ADDR_W(AW), .CNT_W(4)) bus ();

    pfe_dispatch #(.ADDR_W(AW), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .issued_total (issued_total)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [AW-1:0] q0[$];
    logic [AW-1:0] q1[$];
    int            model_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [AW-1:0] a, input logic [11:0] s, input logic [3:0] c);
        int t = 0;
        bus.op_valid  = 1'b1;
        bus.op_addr   = a;
        bus.op_stride = s;
        bus.op_count  = c;
        @(negedge clk);
        while (bus.op_retry && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("op_accept_timeout", 64'(bus.op_retry), 64'd0);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || bus.req0_valid || bus.req1_valid) && t < 200) begin
            t++;
            step(1);
        end
        chk("drain_timeout", 64'(busy || bus.req0_valid || bus.req1_valid), 64'd0);
    endtask

    // Reference model: each accepted op is expanded into its full address list up front
    // and the addresses are queued on the pipe their low bit selects.
    initial begin : compare
        logic          pv0, pr0, pv1, pr1;
        logic [AW-1:0] pa0, pa1, a;
        int            n;
        pv0 = 0; pr0 = 0; pv1 = 0; pr1 = 0; pa0 = '0; pa1 = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                q0.delete();
                q1.delete();
                model_total = 0;
                pv0 = 0; pv1 = 0;
                chk("rst_req0_valid", 64'(bus.req0_valid), 64'd0);
                chk("rst_req1_valid", 64'(bus.req1_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
            end else begin
                chk("retry_vs_busy", 64'(bus.op_retry), 64'(busy));
                chk("issued_total", 64'(issued_total), 64'(model_total));
                if (pv0 && pr0) begin
                    chk("req0_hold_valid", 64'(bus.req0_valid), 64'd1);
                    chk("req0_hold_addr", 64'(bus.req0_addr), 64'(pa0));
                end
                if (pv1 && pr1) begin
                    chk("req1_hold_valid", 64'(bus.req1_valid), 64'd1);
                    chk("req1_hold_addr", 64'(bus.req1_addr), 64'(pa1));
                end
                if (bus.req0_valid && !bus.req0_retry) begin
                    if (q0.size() == 0) chk("req0_unexpected", 64'(bus.req0_addr), 64'hDEAD);
                    else chk("req0_addr", 64'(bus.req0_addr), 64'(q0.pop_front()));
                    if (model_total < 65535) model_total++;
                end
                if (bus.req1_valid && !bus.req1_retry) begin
                    if (q1.size() == 0) chk("req1_unexpected", 64'(bus.req1_addr), 64'hDEAD);
                    else chk("req1_addr", 64'(bus.req1_addr), 64'(q1.pop_front()));
                    if (model_total < 65535) model_total++;
                end
                if (bus.op_valid && !bus.op_retry) begin
                    n = int'(bus.op_count);
`ifdef PFE_DEDUP_EN
                    if (bus.op_stride == 12'd0 && n != 0) n = 1;
`endif
                    a = bus.op_addr;
                    for (int i = 0; i < n; i++) begin
                        if (a[0]) q1.push_back(a);
                        else q0.push_back(a);
                        a = a + {{(AW-12){bus.op_stride[11]}}, bus.op_stride};
                    end
                end
                pv0 = bus.req0_valid; pr0 = bus.req0_retry; pa0 = bus.req0_addr;
                pv1 = bus.req1_valid; pr1 = bus.req1_retry; pa1 = bus.req1_addr;
            end
        end
    end

    initial begin : stim
        reset          = 1'b0;
        bus.op_valid   = 1'b0;
        bus.op_addr    = '0;
        bus.op_stride  = '0;
        bus.op_count   = '0;
        bus.req0_retry = 1'b0;
        bus.req1_retry = 1'b0;
        step(3);
        chk("reset_op_retry", 64'(bus.op_retry), 64'd0);
        chk("reset_total", 64'(issued_total), 64'd0);
        chk("reset_req0_addr", 64'(bus.req0_addr), 64'd0);
        reset = 1'b1;
        step(1);

        // stride 1, count 4, interleaved across both pipes
        send_op(39'h100, 12'd1, 4'd4);
        chk("t1_busy_after_accept", 64'(busy), 64'd1);
        step(1);
        chk("t1_req0_v", 64'(bus.req0_valid), 64'd1);
        chk("t1_req0_a", 64'(bus.req0_addr), 64'h100);
        chk("t1_req1_v_idle", 64'(bus.req1_valid), 64'd0);
        step(1);
        chk("t1_req1_a", 64'(bus.req1_addr), 64'h101);
        step(1);
        chk("t1_req0_a2", 64'(bus.req0_addr), 64'h102);
        step(1);
        chk("t1_req1_a2", 64'(bus.req1_addr), 64'h103);
        chk("t1_busy_low", 64'(busy), 64'd0);
        wait_idle();
        chk("t1_total", 64'(issued_total), 64'd4);

        // req0 back-pressure stalls the expansion
        bus.req0_retry = 1'b1;
        send_op(39'h10, 12'd2, 4'd3);
        step(1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_v", 64'(bus.req0_valid), 64'd1);
            chk("t2_hold_a", 64'(bus.req0_addr), 64'h10);
            chk("t2_stall_busy", 64'(busy), 64'd1);
            if (i < 4) step(1);
        end
        bus.req0_retry = 1'b0;
        step(1);
        chk("t2_a12", 64'(bus.req0_addr), 64'h12);
        step(1);
        chk("t2_a14", 64'(bus.req0_addr), 64'h14);
        chk("t2_busy_low", 64'(busy), 64'd0);
        wait_idle();
        chk("t2_total", 64'(issued_total), 64'd7);

        // negative stride wraps below zero
        send_op(39'h0, 12'hFFF, 4'd2);
        step(1);
        chk("t3_req0_a", 64'(bus.req0_addr), 64'h0);
        step(1);
        chk("t3_req1_v", 64'(bus.req1_valid), 64'd1);
        chk("t3_req1_wrap", 64'(bus.req1_addr), 64'h7F_FFFF_FFFF);
        wait_idle();
        chk("t3_total", 64'(issued_total), 64'd9);

        // stride 0
        send_op(39'h20, 12'd0, 4'd5);
        wait_idle();
`ifdef PFE_DEDUP_EN
        chk("t4_total_dedup", 64'(issued_total), 64'd10);
`else
        chk("t4_total_repeat", 64'(issued_total), 64'd14);
`endif

        // reset mid-op with both slots occupied
        bus.req0_retry = 1'b1;
        bus.req1_retry = 1'b1;
        send_op(39'h200, 12'd1, 4'd4);
        step(2);
        chk("t5_both_v0", 64'(bus.req0_valid), 64'd1);
        chk("t5_both_v1", 64'(bus.req1_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_v0", 64'(bus.req0_valid), 64'd0);
        chk("t5_async_v1", 64'(bus.req1_valid), 64'd0);
        chk("t5_async_a0", 64'(bus.req0_addr), 64'd0);
        chk("t5_async_a1", 64'(bus.req1_addr), 64'd0);
        chk("t5_async_busy", 64'(busy), 64'd0);
        chk("t5_async_retry", 64'(bus.op_retry), 64'd0);
        chk("t5_async_total", 64'(issued_total), 64'd0);
        bus.req0_retry = 1'b0;
        bus.req1_retry = 1'b0;
        step(2);
        reset = 1'b1;
        send_op(39'h300, 12'd1, 4'd0);
        chk("t5_drop_busy", 64'(busy), 64'd0);
        step(3);
        chk("t5_drop_busy_later", 64'(busy), 64'd0);
        chk("t5_drop_no_req", 64'(bus.req0_valid || bus.req1_valid), 64'd0);

        // saturation of issued_total
        for (int i = 0; i < 4368; i++) send_op(39'(i * 16), 12'd1, 4'd15);
        send_op(39'h7000, 12'd1, 4'd14);
        wait_idle();
        chk("t6_total_fffe", 64'(issued_total), 64'hFFFE);
        send_op(39'h40, 12'd1, 4'd3);
        wait_idle();
        chk("t6_total_sat", 64'(issued_total), 64'hFFFF);
        send_op(39'h50, 12'd1, 4'd2);
        wait_idle();
        chk("t6_total_stay", 64'(issued_total), 64'hFFFF);

        step(2);
        chk("end_q0_empty", 64'(q0.size()), 64'd0);
        chk("end_q1_empty", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
